hvsp_target_emu: RTL and testbench
==================================

# hvsp_target_emu

Device-side (responder) end of the high-voltage serial programming link: a synchronous emulator of an 8-pin AVR target in HVSP mode. It receives SCI/SDI/SII from a programmer bitstream, deserialises 11-bit frames and returns a preloaded response byte on SDO. It is used on the FPGA as a loopback target for bench and self-test of the programmer bottomhalf without a physical chip in the ZIF socket.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth for `sci`/`sdi`/`sii`, range 2..3.
- `TIMEOUT_CYCLES`, default 4095: `osc` cycles without an SCI edge mid-frame before the frame is aborted, range 16..65535.

- `osc` input 1: system clock, 12 MHz.
- `rst` input 1: asynchronous, active-high reset.
- `prog_en` input 1: target is in programming mode (RESET pin at HV). Level, synchronous to `osc`.
- `sci` input 1: serial clock from the programmer. Asynchronous.
- `sdi` input 1: serial data in. Asynchronous.
- `sii` input 1: serial instruction in. Asynchronous.
- `sdo` output 1: serial data out.
- `sdo_oe` output 1: SDO drive enable.
- `resp_data` input 8: response byte for the next frame.
- `resp_wr` input 1: one-cycle strobe that loads `resp_data` into the response register.
- `rx_sdi` output 8: SDI payload of the last completed frame.
- `rx_sii` output 8: SII payload of the last completed frame.
- `rx_valid` output 1: one-cycle pulse for a good frame.
- `rx_err` output 1: one-cycle pulse for a framing error or timeout.
- `busy` output 1: a frame is in progress.

## Operation
- **Frame format:** 11 bits, MSB first, bit index 10 down to 0. Bit 10 is the start bit (0). Bits 9..2 are the payload, MSB first. Bits 1..0 are stop bits (0). The same format applies to SDI, SII and SDO.
- **Synchronisation:** `sci`, `sdi` and `sii` each pass through `SYNC_STAGES` flops. An SCI edge is detected by comparing the last synchroniser stage with one extra registered copy.
- **Rising SCI edge:** shift the synchronised SDI and SII into two 11-bit receive registers.
- **Falling SCI edge:** advance the bit counter and drive the next SDO bit.
- **States:**
  - IDLE (counter 0, `busy` 0). First rising edge: load `tx_shift` = {0, resp_reg, 0, 0}, sample bit 10, go to HIGH.
  - HIGH (waiting for a falling edge). Falling edge: counter+1. If counter reaches 11, go to DONE. Otherwise drive `sdo` = `tx_shift[10-counter]` and go to LOW.
  - LOW (waiting for a rising edge). Rising edge: sample bit, go to HIGH.
  - DONE (one cycle):
    - Update `rx_sdi` and `rx_sii` from bits 9..2.
    - If bits 10, 1 and 0 of both receive registers are 0, pulse `rx_valid`; otherwise pulse `rx_err`.
    - Clear the counter, set `sdo` to 0 and return to IDLE.
- **SDO:** `sdo` is 0 in IDLE, which is the start-bit value, so bit 10 is valid before the first rise. `sdo_oe` equals `prog_en` registered one cycle.
- **Response register:** `resp_wr` updates `resp_reg` in any state. `tx_shift` is latched only at the frame's first rise, so a mid-frame write affects only the next frame. When `resp_wr` coincides with the first rising edge, the old value is used.
- **`prog_en` low:**
  - Forces IDLE and clears the counter. No `rx_valid` or `rx_err` is issued.
  - Holds `sdo` at 0; `sdo_oe` drops on the next cycle.
  - SCI edges are ignored while `prog_en` is low.
- **Timeout:** a 16-bit idle counter runs while in HIGH or LOW and resets on every detected SCI edge. When it reaches `TIMEOUT_CYCLES`:
  - Pulse `rx_err` and go to IDLE.
  - `rx_sdi` and `rx_sii` are left unchanged.
- **Simultaneous events:** if a timeout and an SCI edge occur in the same cycle, the edge wins. If `prog_en` drops in the same cycle, `prog_en` wins.

## Timing
- **Reset values:**
  - `sdo`, `sdo_oe`, `busy`, `rx_valid`, `rx_err`: 0.
  - `rx_sdi`, `rx_sii`, `resp_reg`: 8'h00.
  - State: IDLE, counter 0.
- **Edge detection latency:** `SYNC_STAGES`+1 `osc` cycles from the pin edge.
- **SDO update:** `sdo` changes `SYNC_STAGES`+2 cycles after a falling SCI pin edge, which is 333 ns at the defaults. The programmer must keep SCI low for at least `SYNC_STAGES`+3 cycles.
- **Input hold and stability:** SDI and SII must be stable from before the SCI rise until `SYNC_STAGES`+2 cycles after it. SCI high and low phases must each be at least 2 `osc` cycles.
- **Completion:** `rx_valid` / `rx_err` assert exactly 1 cycle after the 11th falling edge is detected. `busy` deasserts in the same cycle.
- **Reset:** asserting `rst` mid-frame clears everything asynchronously, with no pulse.

## Test plan
- **Good frame:** `resp_wr` with 8'hA5, then SDI byte 8'h4C and SII byte 8'h6C framed, SCI period 24 cycles:
  - `rx_valid` pulses once; `rx_sdi` = 8'h4C, `rx_sii` = 8'h6C.
  - Sampled `sdo` bits = 0,1,0,1,0,0,1,0,1,0,0.
- **Framing error:** SDI stop bit 0 sent as 1, payload 8'hFF:
  - `rx_err` pulses and `rx_valid` stays 0.
  - `rx_sdi` = 8'hFF.
- **Timeout:** stop SCI after 5 bits, `TIMEOUT_CYCLES`=64:
  - `rx_err` pulses 64 cycles after the last edge and `busy` drops.
  - A following full frame with 8'h12 gives `rx_valid` and `rx_sdi` = 8'h12.
- **`prog_en` drop:** drop `prog_en` after bit 6:
  - No pulse; `sdo_oe` = 0 next cycle; `busy` = 0.
  - SCI toggles while `prog_en` is low leave `rx_*` unchanged.
- **Mid-frame `resp_wr`:** `resp_reg` 8'h3C, `resp_wr` 8'hC3 at bit 4:
  - The current frame returns 8'h3C and the next frame returns 8'hC3.
- **Reset mid-frame:** `rst` pulse mid-frame:
  - All outputs return to 0 immediately.
  - The next full frame is received correctly.

Source files
------------

// File: rtl/hvsp_target_emu.sv
// HVSP target emulator: receives 11-bit SDI/SII frames clocked by SCI and
// returns a preloaded response byte on SDO, framed the same way.
module hvsp_target_emu #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic       osc,
    input  logic       rst,
    input  logic       prog_en,
    input  logic       sci,
    input  logic       sdi,
    input  logic       sii,
    output logic       sdo,
    output logic       sdo_oe,
    input  logic [7:0] resp_data,
    input  logic       resp_wr,
    output logic [7:0] rx_sdi,
    output logic [7:0] rx_sii,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       busy
);

    // state  | meaning
    // S_IDLE | no frame in progress, sdo holds the start-bit value
    // S_HIGH | bit sampled on SCI rise, waiting for SCI fall
    // S_LOW  | next SDO bit driven, waiting for SCI rise
    // S_DONE | one cycle after the 11th fall, counter and sdo cleared
    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} state_t;

    localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sci_sync, sdi_sync, sii_sync;
    logic                   sci_prev;
    logic                   sci_s, sdi_s, sii_s;
    logic                   rise, fall, edge_any, timeout;

    state_t      state, state_nx;
    logic [3:0]  bit_cnt, bit_cnt_nx, cnt_inc;
    logic [10:0] sdi_sh, sdi_sh_nx, sii_sh, sii_sh_nx;
    logic [10:0] tx_shift, tx_shift_nx;
    logic [15:0] idle_cnt, idle_cnt_nx;
    logic [7:0]  resp_reg, resp_reg_nx;
    logic [7:0]  rx_sdi_nx, rx_sii_nx;
    logic        sdo_nx, rx_valid_nx, rx_err_nx, frame_ok;

    always_ff @(posedge osc or posedge rst) begin
        if (rst) begin
            sci_sync <= '0;
            sdi_sync <= '0;
            sii_sync <= '0;
            sci_prev <= 1'b0;
        end else begin
            sci_sync <= {sci_sync[SYNC_STAGES-2:0], sci};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            sii_sync <= {sii_sync[SYNC_STAGES-2:0], sii};
            sci_prev <= sci_sync[SYNC_STAGES-1];
        end
    end

    assign sci_s    = sci_sync[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync[SYNC_STAGES-1];
    assign sii_s    = sii_sync[SYNC_STAGES-1];
    assign rise     = sci_s & ~sci_prev;
    assign fall     = ~sci_s & sci_prev;
    assign edge_any = rise | fall;
    assign busy     = (state == S_HIGH) || (state == S_LOW);
    // An SCI edge in the same cycle always beats an expiring idle timer.
    assign timeout  = busy && !edge_any && (idle_cnt == 16'd0);
    assign frame_ok = !sdi_sh[10] && (sdi_sh[1:0] == 2'b00) &&
                      !sii_sh[10] && (sii_sh[1:0] == 2'b00);

    always_ff @(posedge osc or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            bit_cnt  <= 4'd0;
            sdi_sh   <= '0;
            sii_sh   <= '0;
            tx_shift <= '0;
            idle_cnt <= '0;
            resp_reg <= 8'h00;
            rx_sdi   <= 8'h00;
            rx_sii   <= 8'h00;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            sdo      <= 1'b0;
            sdo_oe   <= 1'b0;
        end else begin
            state    <= state_nx;
            bit_cnt  <= bit_cnt_nx;
            sdi_sh   <= sdi_sh_nx;
            sii_sh   <= sii_sh_nx;
            tx_shift <= tx_shift_nx;
            idle_cnt <= idle_cnt_nx;
            resp_reg <= resp_reg_nx;
            rx_sdi   <= rx_sdi_nx;
            rx_sii   <= rx_sii_nx;
            rx_valid <= rx_valid_nx;
            rx_err   <= rx_err_nx;
            sdo      <= sdo_nx;
            sdo_oe   <= prog_en;
        end
    end

    always_comb begin
        state_nx    = state;
        bit_cnt_nx  = bit_cnt;
        cnt_inc     = bit_cnt + 4'd1;
        sdi_sh_nx   = sdi_sh;
        sii_sh_nx   = sii_sh;
        tx_shift_nx = tx_shift;
        idle_cnt_nx = idle_cnt;
        resp_reg_nx = resp_wr ? resp_data : resp_reg;
        rx_sdi_nx   = rx_sdi;
        rx_sii_nx   = rx_sii;
        rx_valid_nx = 1'b0;
        rx_err_nx   = 1'b0;
        sdo_nx      = sdo;

        if (!prog_en) begin
            state_nx   = S_IDLE;
            bit_cnt_nx = 4'd0;
            sdo_nx     = 1'b0;
        end else begin
            if (busy) begin
                if (edge_any)
                    idle_cnt_nx = TIMEOUT_LOAD;
                else if (idle_cnt != 16'd0)
                    idle_cnt_nx = idle_cnt - 16'd1;
            end

            case (state)
                S_IDLE: begin
                    if (rise) begin
                        // resp_reg is read before any same-cycle write lands
                        tx_shift_nx = {1'b0, resp_reg, 2'b00};
                        sdi_sh_nx   = {sdi_sh[9:0], sdi_s};
                        sii_sh_nx   = {sii_sh[9:0], sii_s};
                        idle_cnt_nx = TIMEOUT_LOAD;
                        state_nx    = S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (fall) begin
                        bit_cnt_nx = cnt_inc;
                        if (cnt_inc == 4'd11) begin
                            state_nx    = S_DONE;
                            rx_sdi_nx   = sdi_sh[9:2];
                            rx_sii_nx   = sii_sh[9:2];
                            rx_valid_nx = frame_ok;
                            rx_err_nx   = !frame_ok;
                        end else begin
                            sdo_nx   = tx_shift[4'd10 - cnt_inc];
                            state_nx = S_LOW;
                        end
                    end else if (timeout) begin
                        rx_err_nx  = 1'b1;
                        bit_cnt_nx = 4'd0;
                        sdo_nx     = 1'b0;
                        state_nx   = S_IDLE;
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        sdi_sh_nx = {sdi_sh[9:0], sdi_s};
                        sii_sh_nx = {sii_sh[9:0], sii_s};
                        state_nx  = S_HIGH;
                    end else if (timeout) begin
                        rx_err_nx  = 1'b1;
                        bit_cnt_nx = 4'd0;
                        sdo_nx     = 1'b0;
                        state_nx   = S_IDLE;
                    end
                end
                default: begin
                    bit_cnt_nx = 4'd0;
                    sdo_nx     = 1'b0;
                    state_nx   = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hvsp_target_emu.sv
// Bench for hvsp_target_emu: directed vector table, corner-case sequences and
// randomized frames checked against a frame-level reference model.
module tb_hvsp_target_emu;

    localparam int SYNC = 2;
    localparam int TMO  = 64;

    logic       osc = 1'b0;
    logic       rst, prog_en, sci, sdi, sii, resp_wr;
    logic [7:0] resp_data;
    logic       sdo, sdo_oe, rx_valid, rx_err, busy;
    logic [7:0] rx_sdi, rx_sii;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int last_err_cyc = 0;

    hvsp_target_emu #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .osc(osc), .rst(rst), .prog_en(prog_en), .sci(sci), .sdi(sdi), .sii(sii),
        .sdo(sdo), .sdo_oe(sdo_oe), .resp_data(resp_data), .resp_wr(resp_wr),
        .rx_sdi(rx_sdi), .rx_sii(rx_sii), .rx_valid(rx_valid), .rx_err(rx_err),
        .busy(busy)
    );

    always #5 osc = ~osc;

    always @(posedge osc) cyc <= cyc + 1;

    always @(negedge osc) begin
        if (rx_valid) valid_cnt++;
        if (rx_err) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
    end

    typedef struct {
        logic [10:0] fd;
        logic [10:0] fi;
        logic [7:0]  resp;
        logic        exp_valid;
        logic [7:0]  exp_sdi;
        logic [7:0]  exp_sii;
        logic [10:0] exp_sdo;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge osc);
            #1;
        end
    endtask

    task automatic write_resp(input logic [7:0] v);
        resp_data = v;
        resp_wr   = 1'b1;
        tick(1);
        resp_wr   = 1'b0;
    endtask

    // Clocks nbits of a frame out MSB first; sdo is sampled just before each rise.
    task automatic run_frame(input logic [10:0] fd, input logic [10:0] fi, input int nbits,
                             input int hp, input int wr_at, input logic [7:0] wr_val,
                             output logic [10:0] sdo_bits);
        sdo_bits = '0;
        for (int i = 0; i < nbits; i++) begin
            sdi = fd[10-i];
            sii = fi[10-i];
            if (i == wr_at) begin
                write_resp(wr_val);
                tick(hp - 1);
            end else begin
                tick(hp);
            end
            sdo_bits[10-i] = sdo;
            sci = 1'b1;
            tick(hp);
            sci = 1'b0;
        end
    endtask

    logic [10:0] sbits;
    logic [10:0] fd, fi;
    logic [7:0]  model_resp, frame_resp, prev_sdi, prev_sii, nv;
    int          v0, e0, hp, wr_at, waited;
    logic        exp_ok;

    initial begin
        vecs[0] = '{ {1'b0, 8'h4C, 2'b00}, {1'b0, 8'h6C, 2'b00}, 8'hA5, 1'b1, 8'h4C, 8'h6C, 11'b01010010100 };
        vecs[1] = '{ {1'b0, 8'hFF, 2'b01}, {1'b0, 8'h00, 2'b00}, 8'h00, 1'b0, 8'hFF, 8'h00, {1'b0, 8'h00, 2'b00} };
        vecs[2] = '{ {1'b0, 8'h00, 2'b00}, {1'b1, 8'hAA, 2'b00}, 8'hFF, 1'b0, 8'h00, 8'hAA, {1'b0, 8'hFF, 2'b00} };
        vecs[3] = '{ {1'b0, 8'hFF, 2'b00}, {1'b0, 8'hFF, 2'b00}, 8'h5A, 1'b1, 8'hFF, 8'hFF, {1'b0, 8'h5A, 2'b00} };
        vecs[4] = '{ {1'b0, 8'h01, 2'b00}, {1'b0, 8'h80, 2'b00}, 8'h81, 1'b1, 8'h01, 8'h80, {1'b0, 8'h81, 2'b00} };
        vecs[5] = '{ {1'b0, 8'h12, 2'b00}, {1'b0, 8'h00, 2'b01}, 8'h00, 1'b0, 8'h12, 8'h00, {1'b0, 8'h00, 2'b00} };

        rst = 1'b1; prog_en = 1'b0; sci = 1'b0; sdi = 1'b0; sii = 1'b0;
        resp_wr = 1'b0; resp_data = 8'h00;
        tick(3);
        chk("reset_sdo", {31'd0, sdo}, 0);
        chk("reset_sdo_oe", {31'd0, sdo_oe}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_pulses", {30'd0, rx_valid, rx_err}, 0);
        chk("reset_rx", {16'd0, rx_sdi, rx_sii}, 0);
        rst = 1'b0;
        prog_en = 1'b1;
        tick(2);
        chk("sdo_oe_on", {31'd0, sdo_oe}, 1);

        // Directed vector table
        for (int k = 0; k < 6; k++) begin
            write_resp(vecs[k].resp);
            tick(2);
            v0 = valid_cnt; e0 = err_cnt;
            run_frame(vecs[k].fd, vecs[k].fi, 11, 12, -1, 8'h00, sbits);
            tick(10);
            chk($sformatf("vec%0d_valid", k), valid_cnt - v0, {31'd0, vecs[k].exp_valid});
            chk($sformatf("vec%0d_err", k), err_cnt - e0, {31'd0, !vecs[k].exp_valid});
            chk($sformatf("vec%0d_rx_sdi", k), {24'd0, rx_sdi}, {24'd0, vecs[k].exp_sdi});
            chk($sformatf("vec%0d_rx_sii", k), {24'd0, rx_sii}, {24'd0, vecs[k].exp_sii});
            chk($sformatf("vec%0d_sdo", k), {21'd0, sbits}, {21'd0, vecs[k].exp_sdo});
            chk($sformatf("vec%0d_busy", k), {31'd0, busy}, 0);
        end

        // Timeout after 5 bits
        prev_sdi = rx_sdi; prev_sii = rx_sii;
        e0 = err_cnt; v0 = valid_cnt;
        run_frame({1'b0, 8'h77, 2'b00}, {1'b0, 8'h33, 2'b00}, 5, 12, -1, 8'h00, sbits);
        chk("tmo_busy_mid", {31'd0, busy}, 1);
        waited = cyc;
        for (int w = 0; w < 200 && err_cnt == e0; w++) tick(1);
        chk("tmo_err", err_cnt - e0, 1);
        chk("tmo_delay_ok", {31'd0, (last_err_cyc - waited >= TMO) &&
                             (last_err_cyc - waited <= TMO + SYNC + 3)}, 1);
        chk("tmo_no_valid", valid_cnt - v0, 0);
        chk("tmo_busy", {31'd0, busy}, 0);
        chk("tmo_rx_kept", {16'd0, rx_sdi, rx_sii}, {16'd0, prev_sdi, prev_sii});
        v0 = valid_cnt;
        run_frame({1'b0, 8'h12, 2'b00}, {1'b0, 8'h21, 2'b00}, 11, 12, -1, 8'h00, sbits);
        tick(10);
        chk("tmo_next_valid", valid_cnt - v0, 1);
        chk("tmo_next_sdi", {24'd0, rx_sdi}, 32'h12);

        // prog_en drop after bit 6
        prev_sdi = rx_sdi; prev_sii = rx_sii;
        e0 = err_cnt; v0 = valid_cnt;
        run_frame({1'b0, 8'h99, 2'b00}, {1'b0, 8'h66, 2'b00}, 6, 12, -1, 8'h00, sbits);
        tick(4);
        prog_en = 1'b0;
        tick(1);
        chk("pe_sdo_oe", {31'd0, sdo_oe}, 0);
        chk("pe_busy", {31'd0, busy}, 0);
        chk("pe_sdo", {31'd0, sdo}, 0);
        run_frame({1'b0, 8'hF0, 2'b00}, {1'b0, 8'h0F, 2'b00}, 11, 8, -1, 8'h00, sbits);
        tick(TMO + 20);
        chk("pe_no_pulse", (valid_cnt - v0) + (err_cnt - e0), 0);
        chk("pe_rx_kept", {16'd0, rx_sdi, rx_sii}, {16'd0, prev_sdi, prev_sii});
        prog_en = 1'b1;
        tick(3);
        chk("pe_sdo_oe_back", {31'd0, sdo_oe}, 1);

        // Mid-frame response write
        write_resp(8'h3C);
        run_frame({1'b0, 8'h01, 2'b00}, {1'b0, 8'h02, 2'b00}, 11, 12, 4, 8'hC3, sbits);
        tick(10);
        chk("midwr_cur", {21'd0, sbits}, {21'd0, 1'b0, 8'h3C, 2'b00});
        run_frame({1'b0, 8'h03, 2'b00}, {1'b0, 8'h04, 2'b00}, 11, 12, -1, 8'h00, sbits);
        tick(10);
        chk("midwr_next", {21'd0, sbits}, {21'd0, 1'b0, 8'hC3, 2'b00});

        // Reset mid-frame
        e0 = err_cnt; v0 = valid_cnt;
        run_frame({1'b0, 8'hDE, 2'b00}, {1'b0, 8'hAD, 2'b00}, 6, 12, -1, 8'h00, sbits);
        #2 rst = 1'b1;
        #2;
        chk("rst_outs", {20'd0, sdo, sdo_oe, busy, rx_valid, rx_err, rx_sdi[3:0], rx_sii[2:0]}, 0);
        chk("rst_rx", {16'd0, rx_sdi, rx_sii}, 0);
        tick(2);
        rst = 1'b0;
        tick(3);
        chk("rst_no_pulse", (valid_cnt - v0) + (err_cnt - e0), 0);
        run_frame({1'b0, 8'hB7, 2'b00}, {1'b0, 8'h7B, 2'b00}, 11, 12, -1, 8'h00, sbits);
        tick(10);
        chk("rst_next_valid", valid_cnt - v0, 1);
        chk("rst_next_rx", {16'd0, rx_sdi, rx_sii}, {16'd0, 8'hB7, 8'h7B});
        chk("rst_next_sdo", {21'd0, sbits}, 0);

        // Randomized frames against the frame-level model
        model_resp = 8'h00;
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                model_resp = 8'($urandom);
                write_resp(model_resp);
            end
            fd = {1'b0, 8'($urandom), 2'b00};
            fi = {1'b0, 8'($urandom), 2'b00};
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0: fd[10] = 1'b1;
                    1: fi[1]  = 1'b1;
                    default: fd[0] = 1'b1;
                endcase
            end
            exp_ok = (fd[10] == 1'b0) && (fd[1:0] == 2'b00) && (fi[10] == 1'b0) && (fi[1:0] == 2'b00);
            frame_resp = model_resp;
            wr_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : -1;
            nv = 8'($urandom);
            if (wr_at >= 0) model_resp = nv;
            hp = int'($urandom_range(6, 12));
            v0 = valid_cnt; e0 = err_cnt;
            run_frame(fd, fi, 11, hp, wr_at, nv, sbits);
            tick(10);
            chk($sformatf("rnd%0d_valid", n), valid_cnt - v0, {31'd0, exp_ok});
            chk($sformatf("rnd%0d_err", n), err_cnt - e0, {31'd0, !exp_ok});
            chk($sformatf("rnd%0d_rx", n), {16'd0, rx_sdi, rx_sii}, {16'd0, fd[9:2], fi[9:2]});
            chk($sformatf("rnd%0d_sdo", n), {21'd0, sbits}, {21'd0, 1'b0, frame_resp, 2'b00});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
